// File: rtl/serial_double_dabble_if.sv
// Handshake and result bundle between serial_double_dabble and its controller/upstream PISO.
// The overflow signal exists only when DD_OVERFLOW_EN is defined.
interface serial_double_dabble_if #(
  parameter int N_DIGITS = 3
);
  logic                  start;
  logic                  serial_in;
  logic                  src_mode;
  logic                  busy;
  logic                  done;
  logic [4*N_DIGITS-1:0] bcd_out;
`ifdef DD_OVERFLOW_EN
  logic                  overflow;

  modport master (output start, serial_in, input src_mode, busy, done, bcd_out, overflow);
  modport slave  (input start, serial_in, output src_mode, busy, done, bcd_out, overflow);
`else
  modport master (output start, serial_in, input src_mode, busy, done, bcd_out);
  modport slave  (input start, serial_in, output src_mode, busy, done, bcd_out);
`endif
endinterface

// File: rtl/serial_double_dabble.sv
// Serial shift-and-add-3 binary-to-BCD converter fed MSB first by an upstream PISO.
// Optional sticky overflow output when DD_OVERFLOW_EN is defined.
module serial_double_dabble #(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  serial_double_dabble_if.slave bus
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [W-1:0]  adj;
  logic [W-1:0]  next_acc;
  logic [W-1:0]  bcd_q;
  logic [CW-1:0] cnt;

  // Each digit is corrected on its own; no carry ripples between digits.
  always_comb begin
    adj = acc;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign next_acc = {adj[W-2:0], bus.serial_in};

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= next_acc;
          cnt <= cnt + CW'(1);
          // The final shift result goes straight to the output register, unadjusted.
          if (cnt == LAST_CNT) begin
            bcd_q <= next_acc;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DD_OVERFLOW_EN
  logic ovf_flag;
  logic ovf_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ovf_flag <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        ovf_flag <= 1'b0;
      end else if (state == SHIFT) begin
        ovf_flag <= ovf_flag | adj[W-1];
        if (cnt == LAST_CNT) begin
          ovf_q <= ovf_flag | adj[W-1];
        end
      end
    end
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.src_mode = (state != SHIFT);
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.bcd_out  = bcd_q;
endmodule

// File: tb/tb_serial_double_dabble.sv
// Bench for serial_double_dabble: PISO model upstream, scoreboard queue on done.
// Builds with 2 result digits when DD_OVERFLOW_EN is defined so overflow can be exercised.
module tb_serial_double_dabble;
`ifdef DD_OVERFLOW_EN
  localparam int ND = 2;
`else
  localparam int ND = 3;
`endif
  localparam int W = 4 * ND;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] bcd;
    logic        ovf2;
  } vec_t;

  typedef struct {
    logic [W-1:0] bcd;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  logic [7:0] piso;
  logic [7:0] piso_din;
  logic [W-1:0] last_bcd;
  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t tbl[8];

  serial_double_dabble_if #(.N_DIGITS(ND)) bus ();

  serial_double_dabble #(.N_BITS(8), .N_DIGITS(ND)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream 8-bit PISO: parallel load while src_mode=1, shift left otherwise.
  always @(posedge clk) begin
    if (bus.src_mode) piso <= piso_din;
    else              piso <= {piso[6:0], 1'b0};
  end
  assign bus.serial_in = piso[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got bcd %0h expected no done", bus.bcd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
`ifdef DD_OVERFLOW_EN
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
`endif
      end
      last_bcd = bus.bcd_out;
    end
  end

  task automatic push_exp(input logic [11:0] bcd12, input logic ovf2);
    exp_t e;
    e.bcd = bcd12[W-1:0];
    e.ovf = ovf2;
    sb.push_back(e);
  endtask

  // One conversion; glitch>0 pulses start during that SHIFT cycle.
  task automatic convert(input logic [7:0] val, input logic [11:0] bcd12, input logic ovf2,
                         input int glitch);
    int n, nb, nm, extra;
    logic stable, got;
    @(negedge clk);
    piso_din = val;
    bus.start = 1'b1;
    push_exp(bcd12, ovf2);
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0; nb = 0; nm = 0; stable = 1'b1; got = 1'b0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      bus.start = (n == glitch);
      if (bus.busy) nb++;
      if (!bus.src_mode) nm++;
      if (bus.busy && bus.bcd_out !== last_bcd) stable = 1'b0;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    chk("done_cycle", 32'(n), 32'd9);
    chk("busy_cycles", 32'(nb), 32'd8);
    chk("shift_mode_cycles", 32'(nm), 32'd8);
    chk("bcd_hold_in_shift", 32'(stable), 32'd1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra++;
    end
    chk("no_restart", 32'(extra), 32'd0);
  endtask

  initial begin
    int n, k, seen;
    int t[3];

    tbl[0] = '{8'd175, 12'h175, 1'b1};
    tbl[1] = '{8'd255, 12'h255, 1'b1};
    tbl[2] = '{8'd0,   12'h000, 1'b0};
    tbl[3] = '{8'd99,  12'h099, 1'b0};
    tbl[4] = '{8'd1,   12'h001, 1'b0};
    tbl[5] = '{8'd128, 12'h128, 1'b1};
    tbl[6] = '{8'd200, 12'h200, 1'b1};
    tbl[7] = '{8'd10,  12'h010, 1'b0};

    bus.start = 1'b0;
    piso_din = 8'd0;
    last_bcd = '0;
    clear = 1'b1;
    #12;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_src_mode", 32'(bus.src_mode), 32'd1);
    chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
`ifdef DD_OVERFLOW_EN
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].val, tbl[i].bcd, tbl[i].ovf2, 0);
    end

    // start re-asserted in SHIFT cycle 3 must be ignored.
    convert(8'd234, 12'h234, 1'b1, 3);

    // clear in SHIFT cycle 4 aborts the conversion.
    @(negedge clk);
    piso_din = 8'd200;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_clear", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 clear = 1'b1;
    #1;
    chk("clear_busy", 32'(bus.busy), 32'd0);
    chk("clear_src_mode", 32'(bus.src_mode), 32'd1);
    chk("clear_bcd_out", 32'(bus.bcd_out), 32'd0);
    last_bcd = '0;
    @(negedge clk);
    clear = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("no_done_after_clear", 32'(seen), 32'd0);
    convert(8'd99, 12'h099, 1'b0, 0);

    // start held high: three back-to-back conversions, done every 10 cycles.
    @(negedge clk);
    piso_din = 8'd175;
    bus.start = 1'b1;
    repeat (3) push_exp(12'h175, 1'b1);
    @(posedge clk);
    #1;
    n = 0; k = 0;
    while (n < 40 && k < 3) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        t[k] = n;
        k++;
        if (k == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("held_first_done", 32'(t[0]), 32'd9);
      chk("held_gap_1", 32'(t[1] - t[0]), 32'd10);
      chk("held_gap_2", 32'(t[2] - t[1]), 32'd10);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end
endmodule
